// File: rtl/dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dmem_responder: data-memory bus responder with RAM and a small MMIO timer/LED window
// Revision: 1.0
// ---------------------------------------------------------------------------
module dmem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic [15:0] led_o,
  output logic        timer_irq_o,
  output logic        bus_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_MMIO = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  logic [31:0]   mem [DEPTH];
  region_e       region_d, region_q;
  logic [AW-1:0] idx;
  logic [1:0]    off;
  logic [31:0]   ram_q;
  logic [31:0]   mmio_rd, mmio_q;
  logic [15:0]   led_d, led_q;
  logic [31:0]   cmp_d, cmp_q;
  logic [31:0]   cnt_q;
  logic          match_d, match_q;
  logic          irq_en_d, irq_en_q;
  logic          bus_err_q;
  logic          sel_led, sel_cmp, sel_status, w1c;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^mem_addr_i[1:0];
  assign idx = mem_addr_i[AW+1:2];
  assign off = mem_addr_i[3:2];

  always_comb begin
    region_d = REG_NONE;
    if (mem_addr_i[31:AW+2] == '0)
      region_d = REG_RAM;
    else if (mem_addr_i[31:4] == MMIO_BASE[31:4])
      region_d = REG_MMIO;
  end

  // RAM kept free of reset so it maps onto block RAM; read-first by construction.
  always_ff @(posedge clk) begin
    if (region_d == REG_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_we_i[i]) mem[idx][8*i +: 8] <= mem_wdata_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ram_q <= '0;
    else       ram_q <= mem[idx];
  end

  assign sel_led    = (region_d == REG_MMIO) && (off == 2'd0);
  assign sel_cmp    = (region_d == REG_MMIO) && (off == 2'd2);
  assign sel_status = (region_d == REG_MMIO) && (off == 2'd3);
  assign w1c        = sel_status && mem_we_i[0] && mem_wdata_i[0];

  always_comb begin
    mmio_rd = '0;
    case (off)
      2'd0:    mmio_rd = {16'h0, led_q};
      2'd1:    mmio_rd = cnt_q;
      2'd2:    mmio_rd = cmp_q;
      default: mmio_rd = {30'h0, irq_en_q, match_q};
    endcase
  end

  always_comb begin
    led_d    = led_q;
    cmp_d    = cmp_q;
    irq_en_d = irq_en_q;
    for (int i = 0; i < 2; i++) begin
      if (sel_led && mem_we_i[i]) led_d[8*i +: 8] = mem_wdata_i[8*i +: 8];
    end
    for (int i = 0; i < 4; i++) begin
      if (sel_cmp && mem_we_i[i]) cmp_d[8*i +: 8] = mem_wdata_i[8*i +: 8];
    end
    if (sel_status && mem_we_i[0]) irq_en_d = mem_wdata_i[1];
    // A fresh match outranks a same-cycle W1C so no event is lost.
    match_d = (cnt_q == cmp_q) || (match_q && !w1c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_q  <= REG_RAM;
      mmio_q    <= '0;
      led_q     <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      cnt_q     <= '0;
      match_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      region_q  <= region_d;
      mmio_q    <= mmio_rd;
      led_q     <= led_d;
      cmp_q     <= cmp_d;
      cnt_q     <= cnt_q + 32'd1;
      match_q   <= match_d;
      irq_en_q  <= irq_en_d;
      if (region_d == REG_NONE) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    unique case (region_q)
      REG_RAM:  mem_rdata_o = ram_q;
      REG_MMIO: mem_rdata_o = mmio_q;
      default:  mem_rdata_o = '0;
    endcase
  end

  assign led_o       = led_q;
  assign timer_irq_o = match_q & irq_en_q;
  assign bus_err_o   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dmem_responder: directed + randomized bench with a behavioural bus model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int          DEPTH     = 256;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] A_LED     = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_CYC     = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_CMP     = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_STAT    = MMIO_BASE + 32'hC;

  logic        clk;
  logic        reset;
  logic [3:0]  mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic [15:0] led_o;
  logic        timer_irq_o;
  logic        bus_err_o;

  dmem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_wdata_i (mem_wdata_i),
    .mem_rdata_o (mem_rdata_o),
    .led_o       (led_o),
    .timer_irq_o (timer_irq_o),
    .bus_err_o   (bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural view of the memory map.
  logic [31:0] ram_m [int];
  logic [15:0] led_m;
  logic [31:0] cmp_m;
  logic [31:0] cnt_m;
  logic        match_m, irqen_m, buserr_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    led_m = '0; cmp_m = 32'hFFFF_FFFF; cnt_m = '0;
    match_m = 1'b0; irqen_m = 1'b0; buserr_m = 1'b0;
  endtask

  // Asserted between edges, so it also exercises discarding an in-flight read.
  task automatic do_reset();
    #3;
    reset = 1'b1; mem_we_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    #1;
    model_reset();
    chk("rst_rdata", mem_rdata_o, 32'h0);
    chk("rst_led", {16'h0, led_o}, 32'h0);
    chk("rst_irq", {31'h0, timer_irq_o}, 32'h0);
    chk("rst_buserr", {31'h0, bus_err_o}, 32'h0);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] exp_rd, old;
    bit          known, is_ram, is_mmio, w1c, nm;
    int          widx;
    mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wd;
    is_ram  = (addr < DEPTH * 4);
    is_mmio = (addr[31:4] == MMIO_BASE[31:4]);
    widx    = int'(addr >> 2);
    known   = 1'b1;
    exp_rd  = '0;
    if (is_ram) begin
      if (ram_m.exists(widx)) exp_rd = ram_m[widx];
      else known = 1'b0;
    end else if (is_mmio) begin
      case (addr[3:2])
        2'd0: exp_rd = {16'h0, led_m};
        2'd1: exp_rd = cnt_m;
        2'd2: exp_rd = cmp_m;
        default: exp_rd = {30'h0, irqen_m, match_m};
      endcase
    end
    nm  = (cnt_m == cmp_m);
    w1c = 1'b0;
    if (is_ram) begin
      if (ram_m.exists(widx) || we == 4'hF) begin
        old = ram_m.exists(widx) ? ram_m[widx] : 32'h0;
        for (int i = 0; i < 4; i++) if (we[i]) old[8*i +: 8] = wd[8*i +: 8];
        ram_m[widx] = old;
      end
    end else if (is_mmio) begin
      case (addr[3:2])
        2'd0: for (int i = 0; i < 2; i++) if (we[i]) led_m[8*i +: 8] = wd[8*i +: 8];
        2'd2: for (int i = 0; i < 4; i++) if (we[i]) cmp_m[8*i +: 8] = wd[8*i +: 8];
        2'd3: if (we[0]) begin irqen_m = wd[1]; w1c = wd[0]; end
        default: ;
      endcase
    end else begin
      buserr_m = 1'b1;
    end
    match_m = nm || (match_m && !w1c);
    cnt_m   = cnt_m + 32'd1;
    @(posedge clk); #1;
    if (known) chk("rdata", mem_rdata_o, exp_rd);
    chk("led", {16'h0, led_o}, {16'h0, led_m});
    chk("irq", {31'h0, timer_irq_o}, {31'h0, match_m & irqen_m});
    chk("buserr", {31'h0, bus_err_o}, {31'h0, buserr_m});
  endtask

  initial begin
    reset = 1'b1; mem_we_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    model_reset();
    do_reset();

    // Full-word write, then read with one-cycle latency.
    step(4'hF, 32'h10, 32'hDEAD_BEEF);
    step(4'h0, 32'h10, 32'h0);
    chk("t1_word", mem_rdata_o, 32'hDEAD_BEEF);

    // Single-lane write merges; we=0000 leaves the word alone.
    step(4'b0100, 32'h10, 32'h00AA_0000);
    step(4'h0, 32'h10, 32'h1234_5678);
    chk("t2_lane", mem_rdata_o, 32'hDEAA_BEEF);
    step(4'h0, 32'h10, 32'hFFFF_FFFF);
    chk("t2_nowe", mem_rdata_o, 32'hDEAA_BEEF);

    // Read-first on a same-cycle write.
    step(4'hF, 32'h20, 32'h5);
    step(4'hF, 32'h20, 32'h1);
    chk("t3_old", mem_rdata_o, 32'h5);
    step(4'h0, 32'h20, 32'h0);
    chk("t3_new", mem_rdata_o, 32'h1);

    // LED lanes and read-only CYCLE.
    step(4'hF, A_LED, 32'h1234_5678);
    chk("t5_led", {16'h0, led_o}, 32'h0000_5678);
    step(4'h0, A_LED, 32'h0);
    chk("t5_ledrd", mem_rdata_o, 32'h0000_5678);
    step(4'hF, A_CYC, 32'h0);
    step(4'h0, A_CYC, 32'h0);

    // Timer compare from a fresh reset so the counter is known.
    do_reset();
    step(4'hF, A_CMP, 32'd20);
    step(4'h1, A_STAT, 32'h2);
    while (cnt_m != 32'd20) step(4'h0, A_STAT, 32'h0);
    chk("t4_pre", {31'h0, timer_irq_o}, 32'h0);
    step(4'h0, A_STAT, 32'h0);
    chk("t4_irq", {31'h0, timer_irq_o}, 32'h1);
    step(4'h0, A_STAT, 32'h0);
    chk("t4_stat", mem_rdata_o, 32'h3);
    step(4'h1, A_STAT, 32'h1);
    chk("t4_w1c", {31'h0, timer_irq_o}, 32'h0);
    step(4'h1, A_STAT, 32'h2);
    step(4'hF, A_CMP, cnt_m + 32'd2);
    step(4'h0, A_STAT, 32'h0);
    step(4'h1, A_STAT, 32'h3);
    chk("t4_setwins", {31'h0, timer_irq_o}, 32'h1);
    step(4'h0, A_STAT, 32'h0);
    chk("t4_stat2", mem_rdata_o, 32'h3);

    // Randomized mix over a small RAM window and the MMIO registers.
    for (int w = 0; w < 16; w++) step(4'hF, 32'(w * 4), $urandom);
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a, d;
      logic [3:0]  we;
      we = 4'($urandom_range(0, 15));
      d  = $urandom;
      if ($urandom_range(0, 9) < 6) begin
        a = 32'($urandom_range(0, 15) * 4);
      end else begin
        a = MMIO_BASE + 32'($urandom_range(0, 3) * 4);
        if (a == A_CMP && $urandom_range(0, 1) == 1) begin
          we = 4'hF;
          d  = cnt_m + 32'($urandom_range(1, 6));
        end
        if (a == A_LED && $urandom_range(0, 1) == 1) we = 4'h0;
      end
      step(we, a, d);
    end

    // Unmapped access: reads zero, sticky error, then reset mid-read.
    step(4'h0, 32'h4000_0000, 32'h0);
    chk("t6_rd0", mem_rdata_o, 32'h0);
    chk("t6_err", {31'h0, bus_err_o}, 32'h1);
    step(4'hF, 32'h4000_0004, 32'hFFFF_FFFF);
    step(4'h0, 32'h10, 32'h0);
    chk("t6_hold", {31'h0, bus_err_o}, 32'h1);
    do_reset();
    step(4'h0, 32'h10, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
